// File: rtl/sd_card_led_pio_blink_if.sv
// Avalon-MM slave bus bundle for the LED/PIO blink port.
// The master drives address, strobes and write data; the slave returns readdata.
interface sd_card_led_pio_blink_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/sd_card_led_pio_blink.sv
// LED/PIO output port with atomic set/clear and per-bit hardware blink.
// A programmable prescaler toggles a phase bit that forces masked LEDs low.
module sd_card_led_pio_blink #(
  parameter int unsigned DATA_W         = 10,
  parameter int unsigned PRESC_W        = 24,
  parameter logic [31:0] RESET_VALUE    = 32'h0000_0000,
  parameter logic [31:0] RESET_PRESCALE = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  sd_card_led_pio_blink_if.slave    bus,
  output logic [DATA_W-1:0]         out_port
);

  localparam logic [2:0] A_DATA  = 3'd0;
  localparam logic [2:0] A_MASK  = 3'd1;
  localparam logic [2:0] A_PRESC = 3'd2;
  localparam logic [2:0] A_CTRL  = 3'd3;
  localparam logic [2:0] A_SET   = 3'd4;
  localparam logic [2:0] A_CLR   = 3'd5;

  localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1'b1);
  localparam logic [PRESC_W-1:0] PRESC_RST  = RESET_PRESCALE[PRESC_W-1:0];

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_r;
  logic [DATA_W-1:0]   data_r;
  logic [DATA_W-1:0]   mask_r;
  logic [PRESC_W-1:0]  presc_r;
  logic [PRESC_W-1:0]  count_r;
  logic                phase_r;

  logic                wr_s;
  logic [DATA_W-1:0]   wd_data_s;
  logic [PRESC_W-1:0]  wd_presc_s;
  logic [31:0]         rdata_s;
  logic                unused_wd_s;

  assign wr_s        = bus.chipselect & ~bus.write_n;
  assign wd_data_s   = bus.writedata[DATA_W-1:0];
  assign wd_presc_s  = bus.writedata[PRESC_W-1:0];
  assign unused_wd_s = ^bus.writedata;

  // DATA and BLINK_MASK registers, including atomic set/clear writes
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r <= RESET_VALUE[DATA_W-1:0];
      mask_r <= {DATA_W{1'b0}};
    end else if (wr_s) begin
      case (bus.address)
        A_DATA:  data_r <= wd_data_s;
        A_MASK:  mask_r <= wd_data_s;
        A_SET:   data_r <= data_r | wd_data_s;
        A_CLR:   data_r <= data_r & ~wd_data_s;
        default: data_r <= data_r;
      endcase
    end else begin
      data_r <= data_r;
    end
  end

  // Prescaler FSM: a PRESCALE write or restart always beats a pending toggle
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= PRESC_RST;
      count_r <= PRESC_RST;
      phase_r <= 1'b0;
      state_r <= (PRESC_RST != PRESC_ZERO) ? ST_RUN : ST_IDLE;
    end else if (wr_s && (bus.address == A_PRESC)) begin
      presc_r <= wd_presc_s;
      count_r <= wd_presc_s;
      phase_r <= 1'b0;
      state_r <= (wd_presc_s != PRESC_ZERO) ? ST_RUN : ST_IDLE;
    end else if (wr_s && (bus.address == A_CTRL) && bus.writedata[0]) begin
      count_r <= presc_r;
      phase_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          count_r <= PRESC_ZERO;
          phase_r <= 1'b0;
        end
        ST_RUN: begin
          if (count_r == PRESC_ZERO) begin
            phase_r <= ~phase_r;
            count_r <= presc_r;
          end else begin
            count_r <= count_r - PRESC_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          count_r <= PRESC_ZERO;
          phase_r <= 1'b0;
        end
      endcase
    end
  end

  // Zero-wait-state read mux, upper bits zero-filled
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (bus.address)
      A_DATA:  rdata_s[DATA_W-1:0]  = data_r;
      A_MASK:  rdata_s[DATA_W-1:0]  = mask_r;
      A_PRESC: rdata_s[PRESC_W-1:0] = presc_r;
      A_CTRL:  rdata_s[0]           = phase_r;
      default: rdata_s              = 32'h0000_0000;
    endcase
  end

  assign bus.readdata = rdata_s;
  assign out_port     = data_r & ~(mask_r & {DATA_W{phase_r}});

endmodule

// File: tb/tb_sd_card_led_pio_blink.sv
// Scoreboard bench: stimulus pushes expected readdata/out_port from a timing-based
// reference model; a negedge monitor pops and compares every cycle.
module tb_sd_card_led_pio_blink;

  localparam logic [9:0]  RV = 10'h2A5;
  localparam logic [23:0] RP = 24'd0;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] rd;
    logic [9:0]  op;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] out_port;

  sd_card_led_pio_blink_if bus();

  sd_card_led_pio_blink #(
    .DATA_W(10),
    .PRESC_W(24),
    .RESET_VALUE(32'h0000_02A5),
    .RESET_PRESCALE(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  // Reference model: phase derived from elapsed edges since the last restart
  logic [9:0]  m_data;
  logic [9:0]  m_mask;
  logic [23:0] m_presc;
  longint      now_edges = 0;
  longint      t0 = 0;
  bit          m_valid = 1'b0;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic logic m_phase();
    longint span;
    if (m_presc == 24'd0) return 1'b0;
    span = longint'(m_presc) + 64'sd1;
    return (((now_edges - t0) / span) % 2) != 0;
  endfunction

  function automatic logic [9:0] exp_out();
    logic ph;
    ph = m_phase();
    return m_data & ~(m_mask & {10{ph}});
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      3'd0: r[9:0]  = m_data;
      3'd1: r[9:0]  = m_mask;
      3'd2: r[23:0] = m_presc;
      3'd3: r[0]    = m_phase();
      default: r    = 32'd0;
    endcase
    return r;
  endfunction

  task automatic model_step(input logic rst, input logic w, input logic [2:0] a,
                            input logic [31:0] wd);
    now_edges++;
    if (rst) begin
      m_data  = RV;
      m_mask  = 10'd0;
      m_presc = RP;
      t0      = now_edges;
      m_valid = 1'b1;
    end else if (w) begin
      case (a)
        3'd0: m_data = wd[9:0];
        3'd1: m_mask = wd[9:0];
        3'd2: begin m_presc = wd[23:0]; t0 = now_edges; end
        3'd3: if (wd[0]) t0 = now_edges;
        3'd4: m_data = m_data | wd[9:0];
        3'd5: m_data = m_data & ~wd[9:0];
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input logic rst, input logic cs, input logic wn,
                     input logic [2:0] a, input logic [31:0] wd);
    exp_t e;
    reset          = rst;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = a;
    bus.writedata  = wd;
    if (m_valid) begin
      e.addr = a;
      e.rd   = exp_rd(a);
      e.op   = exp_out();
      exp_q.push_back(e);
    end
    @(posedge clk);
    model_step(rst, cs & ~wn, a, wd);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    cyc(1'b0, 1'b1, 1'b0, a, wd);
  endtask

  task automatic idle(input logic [2:0] a, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, a, 32'hFFFF_FFFF);
  endtask

  // Monitor: compare each presented cycle against the queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (bus.readdata !== mon_e.rd) begin
        n_fail++;
        $display("FAIL readdata addr=%0d got %h expected %h at %0t",
                 mon_e.addr, bus.readdata, mon_e.rd, $time);
      end
      n_checks++;
      if (out_port !== mon_e.op) begin
        n_fail++;
        $display("FAIL out_port got %h expected %h at %0t", out_port, mon_e.op, $time);
      end
    end
  end

  initial begin
    logic [2:0]  ra;
    logic [31:0] rwd;

    // Reset, then read every address
    cyc(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_0123);
    for (int a = 0; a < 8; a++) idle(3'(a), 1);

    // Atomic set / clear
    wr(3'd0, 32'h0000_00F0);
    wr(3'd4, 32'h0000_0003);
    wr(3'd5, 32'h0000_0010);
    for (int a = 0; a < 8; a++) idle(3'(a), 1);

    // Blink bit 0 with PRESCALE=3 (period 8)
    wr(3'd0, 32'h0000_03FF);
    wr(3'd1, 32'h0000_0001);
    wr(3'd2, 32'd3);
    idle(3'd3, 20);

    // Stop, hold steady, then PRESCALE=1 (period 4)
    wr(3'd2, 32'd0);
    idle(3'd3, 22);
    wr(3'd2, 32'd1);
    idle(3'd3, 10);

    // Restart on the exact terminal-count cycle, then a no-op CONTROL write
    wr(3'd2, 32'd3);
    idle(3'd3, 3);
    wr(3'd3, 32'd1);
    idle(3'd3, 2);
    wr(3'd3, 32'd0);
    idle(3'd3, 10);

    // Reset mid-blink with a concurrent DATA write
    wr(3'd2, 32'd2);
    idle(3'd3, 4);
    cyc(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_0155);
    idle(3'd0, 1);
    idle(3'd2, 1);
    idle(3'd3, 4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      ra  = 3'($urandom_range(0, 7));
      rwd = (ra == 3'd2) ? 32'($urandom_range(0, 5)) : 32'($urandom);
      if ($urandom_range(0, 99) < 2)
        cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rwd);
      else
        cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rwd);
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
